belt_spill: RTL and testbench

//  Save/restore engine for the belt. SPILL reads the newest COUNT belt

---
 rtl/belt_spill.sv | 243 ++++++++++++++++++++++++
 tb/tb_belt_spill.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/belt_spill.sv
// belt_spill: save/restore engine between the belt and the call/return save area.
// Latency: spill emits its first word 3 cycles after start, then 1 word/cycle; fill drops each accepted word in the same cycle.
// Backpressure: spill stalls on out_ready via a 2-entry skid FIFO with credit-limited reads; fill applies in_ready only while words remain.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start_spill, start_fill   1-cycle start strobes, honoured only when idle (spill wins)
//   count                     words to move, sampled with start, clamped to DEPTH
//   busy, done                operation in progress / 1-cycle completion pulse
//   belt_r, belt_rdata        belt relative read index (0 = newest) / data one cycle later
//   belt_drop, belt_wdata     drop strobe and word towards the belt
//   out_valid/ready/data/last spill stream, oldest word first, last marks index 0
//   in_valid/ready/data       fill stream
module belt_spill #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_spill,
  input  logic             start_fill,
  input  logic [IDXW:0]    count,
  output logic             busy,
  output logic             done,
  output logic [IDXW-1:0]  belt_r,
  input  logic [WIDTH-1:0] belt_rdata,
  output logic             belt_drop,
  output logic [WIDTH-1:0] belt_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPILL,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [IDXW:0] DEPTH_C = (IDXW+1)'(DEPTH);
  localparam logic [IDXW:0] ONE_C   = (IDXW+1)'(1);

  state_t state, state_nx;

  logic [IDXW:0]    count_clamp;
  logic             start_any;
  logic [IDXW:0]    left;       // words still to transfer (spill) or accept (fill)
  logic [IDXW:0]    to_issue;   // belt reads still to issue
  logic             primed;     // belt_r has settled on the start index
  logic             rsp_vld;    // belt_rdata carries a requested word this cycle

  // Two-entry skid FIFO; entry 0 is the head and drives the stream directly.
  logic [WIDTH-1:0] ent0, ent1;
  logic             vld0, vld1;

  logic             issue;
  logic             pop;
  logic             push;
  logic             accept;
  logic [2:0]       pending;

  assign count_clamp = (count > DEPTH_C) ? DEPTH_C : count;
  assign start_any   = start_spill | start_fill;

  assign pop     = vld0 & out_ready;
  assign push    = rsp_vld;

  // Words that will occupy the FIFO once everything already read lands.
  // Keeping this below 2 means a push never meets a full FIFO.
  assign pending = 3'(vld0) + 3'(vld1) + 3'(rsp_vld) - 3'(pop);

  assign out_valid = vld0;
  assign out_data  = ent0;

  // ---------------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    out_last   = 1'b0;
    belt_drop  = 1'b0;
    belt_wdata = '0;

    case (state)
      S_IDLE: begin
        if (start_any) begin
          if (count_clamp == '0) begin
            state_nx = S_DONE;
          end else if (start_spill) begin
            state_nx = S_SPILL;
          end else begin
            state_nx = S_FILL;
          end
        end
      end

      S_SPILL: begin
        busy     = 1'b1;
        issue    = primed && (to_issue != '0) && (pending < 3'd2);
        out_last = vld0 && (left == ONE_C);
        if (pop && (left == ONE_C)) begin
          state_nx = S_DONE;
        end
      end

      S_FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          belt_drop  = 1'b1;
          belt_wdata = in_data;
          if (left == ONE_C) begin
            state_nx = S_DONE;
          end
        end
      end

      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and belt read sequencing
  // ---------------------------------------------------------------------------
  // belt_r is loaded with the oldest index at start and presented for one
  // cycle before the first read is counted; this keeps the read index a pure
  // register output and gives the belt a settled address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left     <= '0;
      to_issue <= '0;
      belt_r   <= '0;
      primed   <= 1'b0;
      rsp_vld  <= 1'b0;
    end else begin
      rsp_vld <= issue;
      if (state == S_IDLE && start_any) begin
        left     <= count_clamp;
        to_issue <= count_clamp;
        primed   <= 1'b0;
        if (start_spill && count_clamp != '0) begin
          belt_r <= IDXW'(count_clamp - ONE_C);
        end else begin
          belt_r <= '0;
        end
      end else begin
        if (state == S_SPILL) begin
          primed <= 1'b1;
        end
        if (issue) begin
          to_issue <= to_issue - ONE_C;
          // Hold at 0 after the newest position instead of wrapping.
          if (to_issue > ONE_C) begin
            belt_r <= belt_r - IDXW'(1);
          end
        end
        if (pop || accept) begin
          left <= left - ONE_C;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0 <= '0;
      ent1 <= '0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!vld0) begin
            ent0 <= belt_rdata;
            vld0 <= 1'b1;
          end else begin
            ent1 <= belt_rdata;
            vld1 <= 1'b1;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          vld0 <= vld1;
          vld1 <= 1'b0;
        end
        2'b11: begin
          // Head leaves while a new word lands; occupancy is unchanged.
          if (vld1) begin
            ent0 <= ent1;
            ent1 <= belt_rdata;
          end else begin
            ent0 <= belt_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && vld0 && vld1));

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
    (vld0 && !out_ready) |=> (vld0 && $stable(ent0)));

  a_no_drop_in_spill: assert property (@(posedge clk) disable iff (!rst)
    (state == S_SPILL) |-> !belt_drop);

endmodule

// File: tb/tb_belt_spill.sv
module tb_belt_spill;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_spill;
  logic             start_fill;
  logic [IDXW:0]    count;
  logic             busy;
  logic             done;
  logic [IDXW-1:0]  belt_r;
  logic [WIDTH-1:0] belt_rdata;
  logic             belt_drop;
  logic [WIDTH-1:0] belt_wdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  belt_spill #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_spill(start_spill),
    .start_fill (start_fill),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .belt_r     (belt_r),
    .belt_rdata (belt_rdata),
    .belt_drop  (belt_drop),
    .belt_wdata (belt_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data)
  );

  always #5 clk = ~clk;

  // Belt model: position 0 newest, read data one cycle after the index.
  logic [WIDTH-1:0] belt     [DEPTH];
  logic [WIDTH-1:0] load_img [DEPTH];
  logic             load_en;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) belt[i] <= load_img[i];
    end else if (belt_drop) begin
      for (int i = DEPTH - 1; i > 0; i--) belt[i] <= belt[i-1];
      belt[0] <= belt_wdata;
    end
    belt_rdata <= belt[belt_r];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stream monitor
  logic [WIDTH-1:0] spill_q [$];
  logic             last_q  [$];
  int               xfer_cyc[$];
  logic [WIDTH-1:0] drop_q  [$];
  int first_vld_cyc, done_cnt, done_busy_err, stab_err, max_ahead, acc_cnt;
  int cur_cnt = 0;
  int start_cyc = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  always @(negedge clk) begin
    int ahead;
    if (rst) begin
      if (busy && !in_ready) begin
        ahead = (cur_cnt - 1 - int'(belt_r)) - spill_q.size();
        if (ahead > max_ahead) max_ahead = ahead;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_valid && out_ready) begin
        spill_q.push_back(out_data);
        last_q.push_back(out_last);
        xfer_cyc.push_back(cyc);
      end
      if (belt_drop) drop_q.push_back(belt_wdata);
      if (in_valid && in_ready) acc_cnt++;
      if (done) begin
        done_cnt++;
        if (busy) done_busy_err++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clr_mon();
    spill_q.delete();
    last_q.delete();
    xfer_cyc.delete();
    drop_q.delete();
    first_vld_cyc = -1;
    done_cnt      = 0;
    done_busy_err = 0;
    stab_err      = 0;
    max_ahead     = 0;
    acc_cnt       = 0;
  endtask

  // All tasks below enter and leave 1 time unit after a rising edge.
  task automatic load_belt();
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic start_op(input logic sp, input logic fl, input logic [IDXW:0] c);
    cur_cnt     = (int'(c) > DEPTH) ? DEPTH : int'(c);
    start_spill = sp;
    start_fill  = fl;
    count       = c;
    @(posedge clk); #1;
    start_spill = 1'b0;
    start_fill  = 1'b0;
    start_cyc   = cyc;
  endtask

  task automatic run_op(input string tag, input int budget, input logic toggle);
    logic [3:0] rdy_pat;
    logic       seen;
    rdy_pat = 4'b1001;
    seen    = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
      if (toggle) out_ready = rdy_pat[(n + 1) % 4];
    end
    out_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  logic [WIDTH-1:0] fill_src [$];

  task automatic fill_run(input string tag, input int budget, input logic gaps);
    int   k;
    logic seen;
    k    = 0;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      in_valid = !(gaps && (n == 1 || n == 3 || n == 4)) && (k < fill_src.size());
      in_data  = in_valid ? fill_src[k] : '0;
      @(negedge clk);
      if (in_valid && in_ready) k++;
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},       32'(busy),      32'd0);
    chk({tag, "_done"},       32'(done),      32'd0);
    chk({tag, "_out_valid"},  32'(out_valid), 32'd0);
    chk({tag, "_out_last"},   32'(out_last),  32'd0);
    chk({tag, "_belt_drop"},  32'(belt_drop), 32'd0);
    chk({tag, "_in_ready"},   32'(in_ready),  32'd0);
    chk({tag, "_belt_r"},     32'(belt_r),    32'd0);
    chk({tag, "_out_data"},   out_data,       32'd0);
    chk({tag, "_belt_wdata"}, belt_wdata,     32'd0);
  endtask

  task automatic chk_stream(input string tag, input logic [WIDTH-1:0] exp_q [$]);
    int lasts;
    chk({tag, "_len"}, 32'(spill_q.size()), 32'(exp_q.size()));
    lasts = 0;
    for (int j = 0; j < exp_q.size() && j < spill_q.size(); j++) begin
      chk($sformatf("%s_w%0d", tag, j), spill_q[j], exp_q[j]);
      if (last_q[j]) lasts++;
    end
    if (spill_q.size() > 0) chk({tag, "_last_final"}, 32'(last_q[spill_q.size()-1]), 32'd1);
    chk({tag, "_last_once"}, 32'(lasts), 32'd1);
    chk({tag, "_no_drop"}, 32'(drop_q.size()), 32'd0);
    chk({tag, "_one_done"}, 32'(done_cnt), 32'd1);
  endtask

  logic [WIDTH-1:0] orig   [DEPTH];
  logic [WIDTH-1:0] exp_q  [$];
  logic [WIDTH-1:0] saved  [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start_spill = 1'b0; start_fill = 1'b0; count = '0;
    out_ready = 1'b1; in_valid = 1'b0; in_data = '0; load_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) orig[i] = 32'hC0DE_0000 + 32'(i * 17);
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: spill 4 of 0x10..0x1F with out_ready held high
    for (int i = 0; i < DEPTH; i++) load_img[i] = 32'h1F - 32'(i);
    load_belt();
    clr_mon();
    start_op(1'b1, 1'b0, 5'd4);
    run_op("t1", 40, 1'b0);
    exp_q = '{32'h1C, 32'h1D, 32'h1E, 32'h1F};
    chk_stream("t1", exp_q);
    chk("t1_first_latency", 32'(first_vld_cyc - start_cyc), 32'd3);
    if (xfer_cyc.size() == 4) chk("t1_back_to_back", 32'(xfer_cyc[3] - xfer_cyc[0]), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_done_pulse_once", 32'(done_cnt), 32'd1);
    chk("t1_done_not_busy", 32'(done_busy_err), 32'd0);

    // 2: same spill, out_ready toggling 1,0,0,1
    clr_mon();
    start_op(1'b1, 1'b0, 5'd4);
    run_op("t2", 60, 1'b1);
    chk_stream("t2", exp_q);
    chk("t2_stable_in_stall", 32'(stab_err), 32'd0);
    chk("t2_ahead_le2", 32'(max_ahead <= 2), 32'd1);

    // 3: fill 3 words with gaps; a 4th word is offered but refused
    for (int i = 0; i < DEPTH; i++) load_img[i] = orig[i];
    load_belt();
    clr_mon();
    fill_src = '{32'hA, 32'hB, 32'hC, 32'hD};
    start_op(1'b0, 1'b1, 5'd3);
    fill_run("t3", 40, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hD;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t3_drops", 32'(drop_q.size()), 32'd3);
    chk("t3_accepts", 32'(acc_cnt), 32'd3);
    if (drop_q.size() >= 3) begin
      chk("t3_drop0", drop_q[0], 32'hA);
      chk("t3_drop1", drop_q[1], 32'hB);
      chk("t3_drop2", drop_q[2], 32'hC);
    end
    chk("t3_pos0", belt[0], 32'hC);
    chk("t3_pos1", belt[1], 32'hB);
    chk("t3_pos2", belt[2], 32'hA);
    chk("t3_pos3", belt[3], orig[0]);

    // 4: spill all 16, scramble belt, fill the saved stream back
    load_belt();
    clr_mon();
    start_op(1'b1, 1'b0, 5'd16);
    run_op("t4s", 80, 1'b0);
    exp_q.delete();
    for (int j = 0; j < DEPTH; j++) exp_q.push_back(orig[DEPTH-1-j]);
    chk_stream("t4s", exp_q);
    saved = spill_q;
    for (int i = 0; i < DEPTH; i++) load_img[i] = 32'h5A5A_0000 ^ 32'(i * 3 + 7);
    load_belt();
    clr_mon();
    fill_src = saved;
    start_op(1'b0, 1'b1, 5'd16);
    fill_run("t4f", 80, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) chk($sformatf("t4_pos%0d", i), belt[i], orig[i]);

    // 5a: both starts together -> spill
    clr_mon();
    start_op(1'b1, 1'b1, 5'd4);
    @(negedge clk);
    chk("t5a_busy", 32'(busy), 32'd1);
    chk("t5a_not_fill", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    run_op("t5a", 40, 1'b0);
    exp_q = '{orig[3], orig[2], orig[1], orig[0]};
    chk_stream("t5a", exp_q);

    // 5b: count 0 -> immediate done, no traffic
    clr_mon();
    start_op(1'b1, 1'b0, 5'd0);
    @(negedge clk);
    chk("t5b_done_now", 32'(done), 32'd1);
    chk("t5b_not_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5b_no_stream", 32'(spill_q.size()), 32'd0);
    chk("t5b_no_valid", 32'(first_vld_cyc), 32'hFFFF_FFFF);
    chk("t5b_no_drop", 32'(drop_q.size()), 32'd0);
    chk("t5b_one_done", 32'(done_cnt), 32'd1);

    // 5c: count 20 clamps to 16
    clr_mon();
    start_op(1'b1, 1'b0, 5'd20);
    chk("t5c_start_idx", 32'(belt_r), 32'd15);
    run_op("t5c", 80, 1'b0);
    exp_q.delete();
    for (int j = 0; j < DEPTH; j++) exp_q.push_back(orig[DEPTH-1-j]);
    chk_stream("t5c", exp_q);

    // 6: reset after 2 words of an 8-word spill, then a clean spill of 4
    clr_mon();
    start_op(1'b1, 1'b0, 5'd8);
    begin
      int n;
      n = 0;
      while (spill_q.size() < 2 && n < 40) begin
        @(negedge clk); #2;
        n++;
      end
      chk("t6_two_words", 32'(spill_q.size()), 32'd2);
    end
    rst = 1'b0;
    #1;
    chk_reset("t6rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_after_rst", 32'(busy), 32'd0);
    clr_mon();
    start_op(1'b1, 1'b0, 5'd4);
    chk("t6_start_idx", 32'(belt_r), 32'd3);
    run_op("t6", 40, 1'b0);
    exp_q = '{orig[3], orig[2], orig[1], orig[0]};
    chk_stream("t6", exp_q);
    chk("t6_first_latency", 32'(first_vld_cyc - start_cyc), 32'd3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
